reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//   Parametrised successor of the core register file: one write port, two bypassed read ports,
//   a per-register tag, a per-register pending (scoreboard) bit, and a stream-export engine.
//   The engine sends a contiguous register window (e.g. FC weight rows) to a consumer over a
//   valid/ready handshake. It sits between decode/writeback and the FC/MP accelerators.
// PARAMETERS
//   DATA_W      32  register width
//   ADDR_W      5   address width; NUM_REGS = 2**ADDR_W
//   TAG_W       4   per-register tag width (position/sign flags)
//   STREAM_BASE 25  first register of the export window
//   STREAM_LEN  2   registers in window; 1 <= STREAM_LEN <= NUM_REGS-STREAM_BASE
// PORTS
//   clk_i          in   1       clock, all state on rising edge
//   reset_n        in   1       asynchronous reset, active-low
//   rs_addr_i      in   ADDR_W  read port A address
//   rt_addr_i      in   ADDR_W  read port B address
//   rs_data_o      out  DATA_W  port A data (combinational)
//   rt_data_o      out  DATA_W  port B data (combinational)
//   rs_tag_o       out  TAG_W   port A tag
//   rt_tag_o       out  TAG_W   port B tag
//   rs_busy_o      out  1       port A register pending
//   rt_busy_o      out  1       port B register pending
//   wr_en_i        in   1       write strobe
//   wr_addr_i      in   ADDR_W  write address
//   wr_data_i      in   DATA_W  write data
//   wr_tag_i       in   TAG_W   write tag
//   issue_en_i     in   1       mark issue_addr_i pending (producer in flight)
//   issue_addr_i   in   ADDR_W  register to mark
//   stream_start_i in   1       request window export (pulse)
//   stream_ready_i in   1       consumer accepts beat
//   stream_valid_o out  1       beat valid
//   stream_data_o  out  DATA_W  beat data (registered)
//   stream_last_o  out  1       final beat of window
//   stream_busy_o  out  1       engine not IDLE
// BEHAVIOUR
// - Reset (reset_n=0, any time incl. mid-stream): all regs, tags, pending bits 0; FSM IDLE;
//   stream_valid_o/last_o/busy_o/data_o = 0. Read outputs reflect zeroed array.
// - Reg 0: reads 0/tag 0/busy 0; writes and issues to addr 0 are ignored.
// - Write: on rising edge with wr_en_i, reg[wr_addr_i]<=wr_data_i, tag<=wr_tag_i, pending cleared.
// - Read bypass: if wr_en_i && wr_addr_i==rX_addr_i!=0, the port returns wr_data_i/wr_tag_i, busy=0.
// - Issue: sets pending[issue_addr_i]. Issue and write to same addr in one cycle: data written,
//   pending stays 1 (issue = newer producer wins).
// - FSM IDLE: stream_start_i -> WAIT. start is ignored while not IDLE.
// - WAIT: stay while any window reg pending. When none pending: load stream_data_o=reg[BASE]
//   and idx=0; go SEND. Min start-to-valid latency is 2 cycles.
// - SEND: valid=1; last=(idx==STREAM_LEN-1). data held stable while valid && !ready.
//   On valid&&ready: if last -> IDLE (valid=0); else idx++, data<=reg[BASE+idx+1].
// - Beat data = array contents at the load edge. A same-edge write to that reg is NOT seen.
//   Later writes to already-loaded regs do not alter the beat.
// - Writes/issues to the window during SEND are allowed; no re-check of pending after WAIT.
// TESTING
// 1 reset_n low mid-SEND -> valid/busy drop to 0 async; all reads 0; post-reset start restarts at idx 0.
// 2 write r5=0xDEADBEEF tag 3, read rs=5 same cycle -> rs_data_o=0xDEADBEEF, tag 3, busy 0;
//   write r0=0x1234 -> r0 reads 0.
// 3 issue r7, then rt=7 -> busy 1; same-cycle issue+write r7=0x55 -> busy stays 1, data 0x55.
// 4 r25=0x1743030F, r26=0x08785B1F, start, ready=1 -> valid 2 cycles later;
//   beats 0x1743030F then 0x08785B1F with last=1 on beat 2; then IDLE.
// 5 issue r26, start -> engine waits in WAIT (busy=1, valid=0) until r26 written; stream then sends the new value.
// 6 ready toggled 0,1,0,1 during SEND; write r25 while beat 0 stalled -> data stable; beat 0 keeps old value.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register tags and pending bits, two bypassed read ports, and an
// engine that exports a fixed register window over a valid/ready stream.
module reg_file_scoreboard #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int TAG_W       = 4,
    parameter int STREAM_BASE = 25,
    parameter int STREAM_LEN  = 2
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [TAG_W-1:0]  rs_tag_o,
    output logic [TAG_W-1:0]  rt_tag_o,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    input  logic              stream_start_i,
    input  logic              stream_ready_i,
    output logic              stream_valid_o,
    output logic [DATA_W-1:0] stream_data_o,
    output logic              stream_last_o,
    output logic              stream_busy_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(STREAM_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(STREAM_LEN - 1);
    localparam logic [NUM_REGS-1:0] WIN_MASK =
        ((NUM_REGS'(1) << STREAM_LEN) - NUM_REGS'(1)) << STREAM_BASE;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [TAG_W-1:0]    tags_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q;

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    logic                wr_ok_s;
    logic                iss_ok_s;
    logic                win_pend_s;
    logic [ADDR_W-1:0]   nxt_idx_s;
    logic [ADDR_W-1:0]   nxt_addr_s;

    assign wr_ok_s    = wr_en_i && (wr_addr_i != ADDR_ZERO);
    assign iss_ok_s   = issue_en_i && (issue_addr_i != ADDR_ZERO);
    assign win_pend_s = |(pend_q & WIN_MASK);
    assign nxt_idx_s  = idx_q + IDX_ONE;
    assign nxt_addr_s = BASE_A + nxt_idx_s;

    // Register array, tags and pending bits; an issue on the same edge as a write wins.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
                tags_q[i] <= {TAG_W{1'b0}};
            end
            pend_q <= {NUM_REGS{1'b0}};
        end else begin
            if (wr_ok_s) begin
                regs_q[wr_addr_i] <= wr_data_i;
                tags_q[wr_addr_i] <= wr_tag_i;
                pend_q[wr_addr_i] <= 1'b0;
            end
            if (iss_ok_s) begin
                pend_q[issue_addr_i] <= 1'b1;
            end
        end
    end

    // Read port A with write-through bypass.
    always_comb begin
        if (wr_ok_s && (wr_addr_i == rs_addr_i)) begin
            rs_data_o = wr_data_i;
            rs_tag_o  = wr_tag_i;
            rs_busy_o = 1'b0;
        end else begin
            rs_data_o = regs_q[rs_addr_i];
            rs_tag_o  = tags_q[rs_addr_i];
            rs_busy_o = pend_q[rs_addr_i];
        end
    end

    // Read port B with write-through bypass.
    always_comb begin
        if (wr_ok_s && (wr_addr_i == rt_addr_i)) begin
            rt_data_o = wr_data_i;
            rt_tag_o  = wr_tag_i;
            rt_busy_o = 1'b0;
        end else begin
            rt_data_o = regs_q[rt_addr_i];
            rt_tag_o  = tags_q[rt_addr_i];
            rt_busy_o = pend_q[rt_addr_i];
        end
    end

    // Export engine next state; beats sample the array before any same-edge write lands.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sdata_d = sdata_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (stream_start_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!win_pend_s) begin
                    state_d = ST_SEND;
                    idx_d   = ADDR_ZERO;
                    sdata_d = regs_q[BASE_A];
                    valid_d = 1'b1;
                    last_d  = (LAST_IDX == ADDR_ZERO);
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (valid_q && stream_ready_i) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = nxt_idx_s;
                        sdata_d = regs_q[nxt_addr_s];
                        last_d  = (nxt_idx_s == LAST_IDX);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Export engine state registers.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= ADDR_ZERO;
            sdata_q <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sdata_q <= sdata_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign stream_valid_o = valid_q;
    assign stream_data_o  = sdata_q;
    assign stream_last_o  = last_q;
    assign stream_busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: a behavioural model checked every cycle plus directed
// vectors with literal expectations.
module tb_reg_file_scoreboard;

    localparam int BASE = 25;
    localparam int LEN  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr, issue_addr;
    logic [31:0] rs_data, rt_data, wr_data, s_data;
    logic [3:0]  rs_tag, rt_tag, wr_tag;
    logic        rs_busy, rt_busy, wr_en, issue_en, start, ready, s_valid, s_last, s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_scoreboard dut (
        .clk_i(clk), .reset_n(reset_n),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
        .rs_data_o(rs_data), .rt_data_o(rt_data),
        .rs_tag_o(rs_tag), .rt_tag_o(rt_tag),
        .rs_busy_o(rs_busy), .rt_busy_o(rt_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_tag_i(wr_tag),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .stream_start_i(start), .stream_ready_i(ready),
        .stream_valid_o(s_valid), .stream_data_o(s_data),
        .stream_last_o(s_last), .stream_busy_o(s_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 waiting on pending window, 2 sending beat m_idx.
    logic [31:0] mregs [32];
    logic [3:0]  mtags [32];
    logic        mpend [32];
    int          m_phase, m_idx;
    logic [31:0] m_data;

    function automatic logic window_pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < LEN; i++) p = p | mpend[BASE + i];
        return p;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] <= 32'h0;
                mtags[i] <= 4'h0;
                mpend[i] <= 1'b0;
            end
            m_phase <= 0;
            m_idx   <= 0;
            m_data  <= 32'h0;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                mregs[wr_addr] <= wr_data;
                mtags[wr_addr] <= wr_tag;
                mpend[wr_addr] <= 1'b0;
            end
            if (issue_en && issue_addr != 5'd0) mpend[issue_addr] <= 1'b1;
            if (m_phase == 0) begin
                if (start) m_phase <= 1;
            end else if (m_phase == 1) begin
                if (!window_pending()) begin
                    m_phase <= 2;
                    m_idx   <= 0;
                    m_data  <= mregs[BASE];
                end
            end else begin
                if (ready) begin
                    if (m_idx == LEN - 1) m_phase <= 0;
                    else begin
                        m_idx  <= m_idx + 1;
                        m_data <= mregs[BASE + m_idx + 1];
                    end
                end
            end
        end
    end

    task automatic rd_model(input logic [4:0] a, output logic [31:0] d,
                            output logic [3:0] t, output logic b);
        if (a == 5'd0) begin
            d = 32'h0; t = 4'h0; b = 1'b0;
        end else if (wr_en && wr_addr == a) begin
            d = wr_data; t = wr_tag; b = 1'b0;
        end else begin
            d = mregs[a]; t = mtags[a]; b = mpend[a];
        end
    endtask

    logic [31:0] e_d;
    logic [3:0]  e_t;
    logic        e_b;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        rd_model(rs_addr, e_d, e_t, e_b);
        chk("rs_data", rs_data, e_d);
        chk("rs_tag", 32'(rs_tag), 32'(e_t));
        chk("rs_busy", 32'(rs_busy), 32'(e_b));
        rd_model(rt_addr, e_d, e_t, e_b);
        chk("rt_data", rt_data, e_d);
        chk("rt_tag", 32'(rt_tag), 32'(e_t));
        chk("rt_busy", 32'(rt_busy), 32'(e_b));
        chk("s_valid", 32'(s_valid), 32'(m_phase == 2));
        chk("s_last", 32'(s_last), 32'(m_phase == 2 && m_idx == LEN - 1));
        chk("s_busy", 32'(s_busy), 32'(m_phase != 0));
        chk("s_data", s_data, m_data);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] t);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_tag = t;
    endtask

    initial begin
        reset_n = 1'b0;
        rs_addr = 5'd0; rt_addr = 5'd0; wr_addr = 5'd0; issue_addr = 5'd0;
        wr_data = 32'h0; wr_tag = 4'h0;
        wr_en = 1'b0; issue_en = 1'b0; start = 1'b0; ready = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        rs_addr = 5'd5;
        #1 chk("rst_rs_data", rs_data, 32'h0);
        chk("rst_valid", 32'(s_valid), 32'h0);
        chk("rst_busy", 32'(s_busy), 32'h0);

        // bypass and register 0
        cyc();
        wr(5'd5, 32'hDEADBEEF, 4'd3);
        #1 chk("byp_data", rs_data, 32'hDEADBEEF);
        chk("byp_tag", 32'(rs_tag), 32'd3);
        chk("byp_busy", 32'(rs_busy), 32'd0);
        cyc();
        wr(5'd0, 32'h1234, 4'd1);
        rs_addr = 5'd0;
        #1 chk("r0_byp", rs_data, 32'h0);
        cyc();
        wr_en = 1'b0;
        #1 chk("r0_read", rs_data, 32'h0);
        rs_addr = 5'd5;
        #1 chk("r5_stored", rs_data, 32'hDEADBEEF);

        // pending / issue precedence
        issue_en = 1'b1; issue_addr = 5'd7;
        cyc();
        issue_en = 1'b0; rt_addr = 5'd7;
        #1 chk("iss_busy", 32'(rt_busy), 32'd1);
        issue_en = 1'b1; wr(5'd7, 32'h55, 4'd1);
        cyc();
        issue_en = 1'b0; wr_en = 1'b0;
        #1 chk("iss_wr_busy", 32'(rt_busy), 32'd1);
        chk("iss_wr_data", rt_data, 32'h55);
        wr(5'd7, 32'h66, 4'd2);
        cyc();

        // basic export
        wr(5'd25, 32'h1743030F, 4'd0);
        cyc();
        wr(5'd26, 32'h08785B1F, 4'd0);
        cyc();
        wr_en = 1'b0; start = 1'b1;
        #1 chk("t4_busy0", 32'(s_busy), 32'd0);
        cyc();
        start = 1'b0; ready = 1'b1;
        #1 chk("t4_wait_valid", 32'(s_valid), 32'd0);
        chk("t4_wait_busy", 32'(s_busy), 32'd1);
        cyc();
        #1 chk("t4_b0_valid", 32'(s_valid), 32'd1);
        chk("t4_b0_data", s_data, 32'h1743030F);
        chk("t4_b0_last", 32'(s_last), 32'd0);
        cyc();
        #1 chk("t4_b1_data", s_data, 32'h08785B1F);
        chk("t4_b1_last", 32'(s_last), 32'd1);
        cyc();
        #1 chk("t4_idle_valid", 32'(s_valid), 32'd0);
        chk("t4_idle_busy", 32'(s_busy), 32'd0);
        ready = 1'b0;

        // export waits on a pending window register
        issue_en = 1'b1; issue_addr = 5'd26;
        cyc();
        issue_en = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0; ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1 chk("t5_wait_valid", 32'(s_valid), 32'd0);
            chk("t5_wait_busy", 32'(s_busy), 32'd1);
        end
        wr(5'd26, 32'hCAFEF00D, 4'd5);
        cyc();
        wr_en = 1'b0;
        #1 chk("t5_still_wait", 32'(s_valid), 32'd0);
        cyc();
        #1 chk("t5_b0_data", s_data, 32'h1743030F);
        cyc();
        #1 chk("t5_b1_data", s_data, 32'hCAFEF00D);
        chk("t5_b1_last", 32'(s_last), 32'd1);
        cyc();
        #1 chk("t5_done", 32'(s_valid), 32'd0);
        ready = 1'b0;

        // stalls and writes to an already-loaded beat
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #1 chk("t6_b0_valid", 32'(s_valid), 32'd1);
        chk("t6_b0_data", s_data, 32'h1743030F);
        wr(5'd25, 32'h11112222, 4'd6);
        cyc();
        wr_en = 1'b0;
        #1 chk("t6_stall_data", s_data, 32'h1743030F);
        chk("t6_stall_valid", 32'(s_valid), 32'd1);
        ready = 1'b1;
        cyc();
        #1 chk("t6_b1_data", s_data, 32'hCAFEF00D);
        ready = 1'b0;
        cyc();
        #1 chk("t6_b1_hold", s_data, 32'hCAFEF00D);
        chk("t6_b1_last", 32'(s_last), 32'd1);
        ready = 1'b1;
        cyc();
        #1 chk("t6_done", 32'(s_valid), 32'd0);
        ready = 1'b0; rs_addr = 5'd25;
        #1 chk("t6_r25", rs_data, 32'h11112222);

        // reset in the middle of a send
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #1 chk("t1_pre_valid", 32'(s_valid), 32'd1);
        chk("t1_pre_data", s_data, 32'h11112222);
        reset_n = 1'b0;
        #1 chk("t1_rst_valid", 32'(s_valid), 32'd0);
        chk("t1_rst_busy", 32'(s_busy), 32'd0);
        chk("t1_rst_data", s_data, 32'h0);
        chk("t1_rst_r25", rs_data, 32'h0);
        rt_addr = 5'd7;
        #1 chk("t1_rst_r7", rt_data, 32'h0);
        cyc();
        reset_n = 1'b1;
        wr(5'd25, 32'hA5A5A5A5, 4'd1);
        cyc();
        wr(5'd26, 32'h5A5A5A5A, 4'd2);
        cyc();
        wr_en = 1'b0; start = 1'b1; ready = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #1 chk("t1_re_b0_data", s_data, 32'hA5A5A5A5);
        chk("t1_re_b0_last", 32'(s_last), 32'd0);
        cyc();
        #1 chk("t1_re_b1_data", s_data, 32'h5A5A5A5A);
        chk("t1_re_b1_last", 32'(s_last), 32'd1);
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
